counter_4b: RTL and testbench
=============================

Name: counter_4b

Overview:
- Free-running signed up-counter, 4-bit two's-complement output, single clock domain.
- Used as a basic sequencing/timebase primitive.
- Counts upward by one every clock edge and wraps from the most-positive value to the most-negative value.
- Cleared to zero by a synchronous active-high clear.

Parameters:
- WIDTH, 4, counter width in bits; output range is -(2^(WIDTH-1)) .. 2^(WIDTH-1)-1.
- RST_VAL, 0, signed value loaded on clear; must lie within range.
- STEP, 1, signed increment per clock; only 1 is required to be verified.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous clear, active-high.
- q  output  signed [WIDTH-1:0]  current count, registered.

Behaviour:
- All state updates occur on the rising edge of clk only. There is no asynchronous path.
- Port order is fixed as clk, clr, q. Instantiations connect by position.
- Clear:
  - If clr=1 at a rising edge, q becomes RST_VAL (0) after that edge.
  - Clear has priority over counting.
  - Holding clr high for N edges keeps q at 0 for all N edges.
  - Assertion or deassertion of clr between edges has no effect on q.
- Count:
  - If clr=0 at a rising edge, q becomes q+STEP, modulo 2^WIDTH, interpreted signed.
  - Latency is 1 cycle. After clr deasserts, the first edge yields q=1, the next yields 2, and so on.
- Sequence for WIDTH=4: 0,1,2,3,4,5,6,7,-8,-7,...,-1,0,1,...
  - This is a period of 16 edges.
  - The wrap from 7 to -8 is a normal increment. No overflow flag, no saturation, no stall.
  - The carry out of the MSB is discarded.
- Power-up:
  - No initial value is guaranteed. q is undefined (X in simulation) until the first edge with clr=1.
  - An undefined q stays undefined while counting. Benches must apply clr before checking values.
- Clear during operation: clr mid-count at any value, including 7 or -8, forces 0 on that edge. Counting resumes from 0.
- Arithmetic: perform the addition at WIDTH bits on signed operands and truncate to WIDTH. Do not extend the register.
- q is driven directly from the state register, with no combinational logic on the output path.

Decomposition:
- Package counter_pkg holds:
  - CNT_WIDTH_DEF = 4
  - localparam-style functions or constants for CNT_MAX = 2^(W-1)-1 and CNT_MIN = -2^(W-1)
  - a typedef cnt_t for signed [CNT_WIDTH_DEF-1:0]
- No sub-module. A single always block for the register plus an elaboration-time check that RST_VAL is within CNT_MIN..CNT_MAX.
- Optional simulation-only assertions live in the same file under a synthesis-off guard:
  - q(t+1) == q(t)+1 mod 16 when clr=0
  - q == 0 after clr

Test Plan:
- Clear from unknown: clr=1 for 6 edges starting from an undefined q -> q=0 after the first edge and stays 0 while clr=1.
- Count-up: release clr -> q=1,2,3,...,7 on successive edges.
- Positive wrap: continue counting from 7 -> next edge q=-8 (4'b1000), then -7 ... -1, then 0. The full period is 16 edges.
- Mid-count clear: clr=1 when q=5 -> q=0 on that edge. On release, q=1 on the next edge.
- Clear at boundary: clr=1 exactly when q=7, and again when q=-8 -> q=0 in both cases, with no wrap observed.
- Clear held across wrap point: hold clr for 20 edges -> q remains 0 throughout. Release -> counting restarts at 1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared widths, range helpers and count type for the signed timebase counter.
package counter_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 4;

  // Signed range of a w-bit two's-complement value (w limited to 2..31).
  function automatic int cnt_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int cnt_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

  localparam int CNT_MAX = cnt_max(CNT_WIDTH_DEF);
  localparam int CNT_MIN = cnt_min(CNT_WIDTH_DEF);

  typedef logic signed [CNT_WIDTH_DEF-1:0] cnt_t;

endpackage

// File: rtl/counter_4b_if.sv
// Bundle of the counter's clear request and count value.
interface counter_4b_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
);

  logic                    clr;
  logic signed [WIDTH-1:0] q;

  modport master (output clr, input  q);
  modport slave  (input  clr, output q);

endinterface

// File: rtl/counter_4b.sv
// Free-running signed up-counter with synchronous clear; wraps from max to min.
module counter_4b
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_WIDTH_DEF,
  parameter int          RST_VAL = 0,
  parameter int          STEP    = 1
) (
  input  logic                    clk,
  input  logic                    clr,
  output logic signed [WIDTH-1:0] q
);

  localparam logic signed [WIDTH-1:0] RST_Q  = WIDTH'(RST_VAL);
  localparam logic signed [WIDTH-1:0] STEP_Q = WIDTH'(STEP);

  // Reject parameter sets the counter cannot represent.
  if (WIDTH < 2 || WIDTH > 31) begin : g_bad_width
    $error("counter_4b: WIDTH must be 2..31");
  end
  if (RST_VAL < cnt_min(WIDTH) || RST_VAL > cnt_max(WIDTH)) begin : g_bad_rst_val
    $error("counter_4b: RST_VAL outside signed WIDTH range");
  end

  // Same-width add: carry out of the MSB drops, giving the max->min wrap.
  always_ff @(posedge clk) begin
    if (clr) q <= RST_Q;
    else     q <= q + STEP_Q;
  end

`ifndef SYNTHESIS
  a_clr_loads: assert property (@(posedge clk) clr |=> (q == RST_Q));
  a_count_step: assert property (@(posedge clk)
    (!clr && !$isunknown(q)) |=> (q == $past(q) + STEP_Q));
`endif

endmodule

// File: tb/tb_counter_4b.sv
// Bench for counter_4b: directed boundary cases plus random clear traffic vs. an arithmetic model.
module tb_counter_4b;

  localparam int unsigned W    = 4;
  localparam int          HALF = 1 << (W - 1);
  localparam int          MODV = 1 << W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  counter_4b_if #(.WIDTH(W)) cif ();

  counter_4b #(.WIDTH(W), .RST_VAL(0), .STEP(1)) dut (
    .clk (clk),
    .clr (cif.clr),
    .q   (cif.q)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_q = 0;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: q=%0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Model: increment as an integer, then fold back into the signed range.
  function automatic int model_next(input int v, input bit c);
    if (c) return 0;
    return ((v + HALF + 1) % MODV) - HALF;
  endfunction

  // Drive clr between edges, take one edge, compare just after it.
  task automatic tick(input bit c, input string tag);
    cif.clr = c;
    @(posedge clk);
    exp_q = model_next(exp_q, c);
    #1;
    check(tag, int'(cif.q), exp_q);
  endtask

  // Count (clr low) until the model reaches the target; bounded by one period.
  task automatic count_to(input int target, input string tag);
    for (int i = 0; i < MODV && exp_q != target; i++) tick(1'b0, tag);
  endtask

  initial begin
    cif.clr = 1'b1;

    // Clear from undefined power-up state, held for 6 edges.
    for (int i = 0; i < 6; i++) tick(1'b1, "clr_from_x");

    // Count up to 7, then wrap through -8 back to 0 (one full period total).
    for (int i = 0; i < 7; i++) tick(1'b0, "count_up");
    check("at_max", int'(cif.q), 7);
    tick(1'b0, "wrap_pos");
    check("wrap_min", int'(cif.q), -8);
    for (int i = 0; i < 8; i++) tick(1'b0, "neg_half");
    check("period_zero", int'(cif.q), 0);

    // Mid-count clear at 5, then release.
    count_to(5, "to_5");
    tick(1'b1, "clr_at_5");
    check("clr_at_5_zero", int'(cif.q), 0);
    tick(1'b0, "rel_after_5");
    check("rel_after_5_one", int'(cif.q), 1);

    // Clear exactly at 7: no wrap to -8 observed.
    count_to(7, "to_7");
    tick(1'b1, "clr_at_7");
    tick(1'b0, "rel_after_7");

    // Clear exactly at -8.
    count_to(-8, "to_min");
    check("reached_min", int'(cif.q), -8);
    tick(1'b1, "clr_at_min");
    tick(1'b0, "rel_after_min");

    // Clear held for 20 edges across where the wrap would have been.
    count_to(6, "to_6");
    for (int i = 0; i < 20; i++) tick(1'b1, "clr_hold");
    tick(1'b0, "rel_after_hold");
    check("restart_one", int'(cif.q), 1);

    // Random clear traffic, including toggles between edges that must be ignored.
    for (int i = 0; i < 400; i++) begin
      bit c;
      c = ($urandom_range(0, 7) == 0);
      cif.clr = ~c;
      #2;
      tick(c, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
